evm_result_tx: RTL and testbench

EVM_RESULT_TX -- requirements
Module: evm_result_tx

---
 rtl/evm_pkg.sv | 27 ++
 rtl/evm_uart_byte_tx.sv | 120 ++++++++++++
 rtl/evm_result_tx.sv | 138 +++++++++++++
 tb/tb_evm_result_tx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/evm_pkg.sv
// evm_pkg -- shared constants and types for the EVM result transmitter.
//   HDR_BYTE     : first byte of every result frame
//   NUM_CANDS    : number of candidate tallies carried in a frame
//   FRAME_LEN    : bytes per frame; 7 when EVM_WINNER_EN is defined, else 6
//   tx_state_e   : per-byte serializer state
// Build option: EVM_WINNER_EN adds a winner byte ahead of the checksum.
package evm_pkg;

   localparam logic [7:0] HDR_BYTE       = 8'hA5;
   localparam int         NUM_CANDS      = 4;
   localparam int         FRAME_LEN_BASE = 6;
   localparam int         FRAME_LEN_WIN  = 7;

`ifdef EVM_WINNER_EN
   localparam int         FRAME_LEN      = FRAME_LEN_WIN;
`else
   localparam int         FRAME_LEN      = FRAME_LEN_BASE;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/evm_uart_byte_tx.sv
// evm_uart_byte_tx -- serializes one byte as start(0), 8 data bits LSB first,
// stop(1); each bit lasts CLKS_PER_BIT cycles.
//   clock, reset : system clock, synchronous active-high reset
//   load         : take data_in; honoured in IDLE or in the final STOP cycle
//   data_in      : byte to send
//   tx           : serial line, idle high (registered)
//   busy         : serializer is not IDLE
//   stop_end     : final cycle of the stop bit; a load here chains the next
//                  byte with no idle gap
//
// state | meaning
// IDLE  | line high, waiting for load
// START | driving start bit (0)
// DATA  | driving data bits, LSB first
// STOP  | driving stop bit (1)
module evm_uart_byte_tx
   import evm_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] data_in,
   output logic       tx,
   output logic       busy,
   output logic       stop_end
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

   tx_state_e     state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          baud_tc;

   assign baud_tc  = (baud_q == '0);
   assign stop_end = (state_q == STOP) && baud_tc;
   assign busy     = (state_q != IDLE);
   assign tx       = tx_q;

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      case (state_q)
         IDLE: begin
            if (load) begin
               state_d = START;
               baud_d  = BAUD_RELOAD;
               shift_d = data_in;
            end
         end
         START: begin
            if (baud_tc) begin
               state_d = DATA;
               baud_d  = BAUD_RELOAD;
               bit_d   = 3'd7;
            end else begin
               baud_d = baud_q - BW'(1);
            end
         end
         DATA: begin
            if (baud_tc) begin
               baud_d  = BAUD_RELOAD;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd0) begin
                  state_d = STOP;
               end else begin
                  bit_d = bit_q - 3'd1;
               end
            end else begin
               baud_d = baud_q - BW'(1);
            end
         end
         STOP: begin
            if (baud_tc) begin
               if (load) begin
                  state_d = START;
                  baud_d  = BAUD_RELOAD;
                  shift_d = data_in;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q - BW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Line level is registered from the next state so tx never glitches.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

endmodule

// File: rtl/evm_result_tx.sv
// evm_result_tx -- sends a snapshot of the four candidate tallies as a UART
// frame: A5, cand1..cand4, [winner], checksum.
//   clock, reset         : system clock, synchronous active-high reset
//   mode                 : 0 = voting, 1 = result (requests honoured only here)
//   send_req             : start a frame when idle in result mode
//   cand1..cand4_votes   : live tallies, sampled once at frame acceptance
//   tx                   : serial line, idle high
//   busy                 : frame in progress
//   done                 : one-cycle pulse after the last stop bit
// Build option: EVM_WINNER_EN inserts a winner byte (1..4, 0 if all zero)
// before the checksum, and folds it into the checksum.
module evm_result_tx
   import evm_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       mode,
   input  logic       send_req,
   input  logic [7:0] cand1_votes,
   input  logic [7:0] cand2_votes,
   input  logic [7:0] cand3_votes,
   input  logic [7:0] cand4_votes,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN);

   logic [7:0] snap_q [NUM_CANDS];
   logic [7:0] snap_d [NUM_CANDS];
   logic [2:0] idx_q, idx_d;
   logic       done_q, done_d;
   logic       accept, load, stop_end;
   logic [7:0] load_byte, frame_byte, checksum;

`ifdef EVM_WINNER_EN
   logic [7:0] winner;
   logic [7:0] best;

   // Strict compare keeps the lowest index on ties and yields 0 when all are 0.
   always_comb begin
      winner = 8'd0;
      best   = 8'd0;
      for (int i = 0; i < NUM_CANDS; i++) begin
         if (snap_q[i] > best) begin
            best   = snap_q[i];
            winner = 8'(i + 1);
         end
      end
   end
`endif

   always_comb begin
      checksum = 8'd0;
      for (int i = 0; i < NUM_CANDS; i++) begin
         checksum = checksum + snap_q[i];
      end
`ifdef EVM_WINNER_EN
      checksum = checksum + winner;
`endif
   end

   always_comb begin
      case (idx_q)
         3'd1:    frame_byte = snap_q[0];
         3'd2:    frame_byte = snap_q[1];
         3'd3:    frame_byte = snap_q[2];
         3'd4:    frame_byte = snap_q[3];
`ifdef EVM_WINNER_EN
         3'd5:    frame_byte = winner;
         3'd6:    frame_byte = checksum;
`else
         3'd5:    frame_byte = checksum;
`endif
         default: frame_byte = HDR_BYTE;
      endcase
   end

   assign accept = send_req && mode && !busy;

   // idx_q is the index of the next byte to hand to the serializer.
   always_comb begin
      snap_d    = snap_q;
      idx_d     = idx_q;
      done_d    = 1'b0;
      load      = 1'b0;
      load_byte = HDR_BYTE;
      if (accept) begin
         load      = 1'b1;
         snap_d[0] = cand1_votes;
         snap_d[1] = cand2_votes;
         snap_d[2] = cand3_votes;
         snap_d[3] = cand4_votes;
         idx_d     = 3'd1;
      end else if (stop_end) begin
         if (idx_q < LAST_IDX) begin
            load      = 1'b1;
            load_byte = frame_byte;
            idx_d     = idx_q + 3'd1;
         end else begin
            done_d = 1'b1;
            idx_d  = 3'd0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         idx_q  <= '0;
         done_q <= 1'b0;
         for (int i = 0; i < NUM_CANDS; i++) begin
            snap_q[i] <= '0;
         end
      end else begin
         idx_q  <= idx_d;
         done_q <= done_d;
         snap_q <= snap_d;
      end
   end

   evm_uart_byte_tx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_byte_tx (
      .clock    (clock),
      .reset    (reset),
      .load     (load),
      .data_in  (load_byte),
      .tx       (tx),
      .busy     (busy),
      .stop_end (stop_end)
   );

   assign done = done_q;

endmodule

// File: tb/tb_evm_result_tx.sv
// tb_evm_result_tx -- directed bench for evm_result_tx at CLKS_PER_BIT=4.
// Honours EVM_WINNER_EN the same way as the design (7-byte vs 6-byte frame).
module tb_evm_result_tx;

   localparam int CPB = 4;
   localparam int BIT_CYC = CPB;
   localparam int BYTE_CYC = 10 * CPB;
`ifdef EVM_WINNER_EN
   localparam int NB = 7;
`else
   localparam int NB = 6;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic       mode;
   logic       send_req;
   logic [7:0] c1, c2, c3, c4;
   logic       tx, busy, done;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] cap   [7];
   logic [7:0] exp_b [7];
   int busy_cyc, dones, done_at, frame_err;
   logic tx_at_done;

   evm_result_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clock       (clock),
      .reset       (reset),
      .mode        (mode),
      .send_req    (send_req),
      .cand1_votes (c1),
      .cand2_votes (c2),
      .cand3_votes (c3),
      .cand4_votes (c4),
      .tx          (tx),
      .busy        (busy),
      .done        (done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Hand-computed winner (w) and checksum (k) are supplied by the caller.
   task automatic set_exp(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic [7:0] d, input logic [7:0] w, input logic [7:0] k);
`ifdef EVM_WINNER_EN
      exp_b = '{8'hA5, a, b, c, d, w, k};
`else
      exp_b = '{8'hA5, a, b, c, d, k, 8'h00};
`endif
   endtask

   // Pulses send_req, then watches the line for a full frame plus 4 cycles.
   // Cycle 0 is the first cycle after acceptance. poke_kind 1 = extra
   // send_req, 2 = change tallies and drop mode, applied at cycle poke_at.
   task automatic run_frame(input int poke_at, input int poke_kind);
      int nb_cyc;
      int b, k;
      nb_cyc = NB * BYTE_CYC;
      busy_cyc = 0; dones = 0; done_at = -1; frame_err = 0; tx_at_done = 1'bx;
      for (int i = 0; i < 7; i++) cap[i] = 8'h00;
      @(negedge clock); send_req = 1'b1;
      @(negedge clock); send_req = 1'b0;
      for (int c = 0; c < nb_cyc + 4; c++) begin
         if (c > 0) @(negedge clock);
         send_req = 1'b0;
         if (c == poke_at) begin
            if (poke_kind == 1) send_req = 1'b1;
            if (poke_kind == 2) begin
               c1 = 8'd9; c2 = 8'd9; c3 = 8'd9; c4 = 8'd9; mode = 1'b0;
            end
         end
         if (busy === 1'b1) busy_cyc++;
         if (done === 1'b1) begin
            dones++;
            if (done_at < 0) begin
               done_at = c;
               tx_at_done = tx;
            end
         end
         if (c < nb_cyc && (c % BIT_CYC) == BIT_CYC / 2) begin
            b = c / BYTE_CYC;
            k = (c % BYTE_CYC) / BIT_CYC;
            if (k == 0) begin
               if (tx !== 1'b0) frame_err++;
            end else if (k == 9) begin
               if (tx !== 1'b1) frame_err++;
            end else begin
               cap[b][k-1] = tx;
            end
         end
      end
      send_req = 1'b0;
   endtask

   task automatic check_frame(input string tag);
      for (int i = 0; i < NB; i++) chk($sformatf("%s_byte%0d", tag, i), 32'(cap[i]), 32'(exp_b[i]));
      chk({tag, "_busy_cycles"}, busy_cyc, NB * BYTE_CYC);
      chk({tag, "_done_count"}, dones, 1);
      chk({tag, "_done_cycle"}, done_at, NB * BYTE_CYC);
      chk({tag, "_tx_in_done"}, 32'(tx_at_done), 1);
      chk({tag, "_framing"}, frame_err, 0);
   endtask

   initial begin
      int bad;
      reset = 1'b1; mode = 1'b1; send_req = 1'b0;
      c1 = 8'd0; c2 = 8'd0; c3 = 8'd0; c4 = 8'd0;
      repeat (3) @(negedge clock);
      chk("reset_tx", 32'(tx), 1);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_done", 32'(done), 0);
      reset = 1'b0;
      @(negedge clock);

      // Basic frame 3,5,0,7
      c1 = 8'd3; c2 = 8'd5; c3 = 8'd0; c4 = 8'd7;
      set_exp(8'h03, 8'h05, 8'h00, 8'h07, 8'h04, `ifdef EVM_WINNER_EN 8'h13 `else 8'h0F `endif);
      run_frame(-1, 0);
      check_frame("f3507");

      // Checksum wraparound 200,100,0,0
      c1 = 8'd200; c2 = 8'd100; c3 = 8'd0; c4 = 8'd0;
      set_exp(8'd200, 8'd100, 8'h00, 8'h00, 8'h01, `ifdef EVM_WINNER_EN 8'h2D `else 8'h2C `endif);
      run_frame(-1, 0);
      check_frame("fwrap");

      // Tie -> lowest index
      c1 = 8'd5; c2 = 8'd5; c3 = 8'd0; c4 = 8'd0;
      set_exp(8'h05, 8'h05, 8'h00, 8'h00, 8'h01, `ifdef EVM_WINNER_EN 8'h0B `else 8'h0A `endif);
      run_frame(-1, 0);
      check_frame("ftie");

      // All zero -> winner 0, checksum 0
      c1 = 8'd0; c2 = 8'd0; c3 = 8'd0; c4 = 8'd0;
      set_exp(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      run_frame(-1, 0);
      check_frame("fzero");

      // Request in voting mode is ignored
      mode = 1'b0;
      @(negedge clock); send_req = 1'b1;
      @(negedge clock); send_req = 1'b0;
      bad = 0; dones = 0;
      for (int c = 0; c < 50; c++) begin
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
         if (done === 1'b1) dones++;
         @(negedge clock);
      end
      chk("mode0_idle_line", bad, 0);
      chk("mode0_no_done", dones, 0);
      mode = 1'b1;

      // Second request mid-frame is ignored
      c1 = 8'd3; c2 = 8'd5; c3 = 8'd0; c4 = 8'd7;
      set_exp(8'h03, 8'h05, 8'h00, 8'h07, 8'h04, `ifdef EVM_WINNER_EN 8'h13 `else 8'h0F `endif);
      run_frame(100, 1);
      check_frame("freq2");

      // Tallies change and mode drops mid-frame -> snapshot frame completes
      c1 = 8'd1; c2 = 8'd2; c3 = 8'd3; c4 = 8'd4;
      set_exp(8'h01, 8'h02, 8'h03, 8'h04, 8'h04, `ifdef EVM_WINNER_EN 8'h0E `else 8'h0A `endif);
      run_frame(60, 2);
      check_frame("fsnap");
      mode = 1'b1;

      // Reset during a data bit aborts without done
      c1 = 8'd10; c2 = 8'd20; c3 = 8'd30; c4 = 8'd40;
      @(negedge clock); send_req = 1'b1;
      @(negedge clock); send_req = 1'b0;
      repeat (50) @(negedge clock);
      chk("abort_busy_before", 32'(busy), 1);
      reset = 1'b1;
      @(negedge clock);
      chk("abort_tx", 32'(tx), 1);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_done", 32'(done), 0);
      reset = 1'b0;
      bad = 0; dones = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clock);
         if (busy !== 1'b0 || tx !== 1'b1) bad++;
         if (done === 1'b1) dones++;
      end
      chk("abort_stays_idle", bad, 0);
      chk("abort_no_done", dones, 0);

      // Fresh frame after the abort
      set_exp(8'd10, 8'd20, 8'd30, 8'd40, 8'h04, `ifdef EVM_WINNER_EN 8'h68 `else 8'h64 `endif);
      run_frame(-1, 0);
      check_frame("fpost");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
